alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage on the producer side of the regfileALU interface. Decodes a RV32I
//  instruction into the 4-bit ALU_ctrl code and selects op1/op2, then presents them to
//  the ALU through a registered valid/ready pipeline slot with a one-entry skid buffer.
//  Sits between regfile read and the ALU. Full throughput, 1-cycle latency, flushable.
// PARAMETERS
//  DATA_WIDTH  32  operand width; must match ALU Data_Width
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   upstream offers instr/operands this cycle
//  in_ready    out  1   stage can accept; equals !skid_valid (registered)
//  instr       in   32  raw instruction word
//  rs1_data    in   DW  register rs1 contents
//  rs2_data    in   DW  register rs2 contents
//  imm         in   DW  immediate, already sign-extended / U-shifted upstream
//  flush       in   1   discard all held entries (branch taken / trap)
//  out_valid   out  1   op1/op2/alu_ctrl/flags valid toward ALU
//  out_ready   in   1   downstream consumes the entry this cycle
//  op1         out  DW  ALU op1
//  op2         out  DW  ALU op2
//  alu_ctrl    out  4   ALU control code
//  is_branch   out  1   entry is a conditional branch; ALU eq selects PC
//  br_invert   out  1   branch taken on eq==0 (BNE)
//  illegal     out  1   opcode/funct not supported; alu_ctrl forced 0000
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, skid_valid=0, in_ready=1, op1=op2=0, alu_ctrl=0000,
//   is_branch=br_invert=illegal=0. Outputs stay at these values until the first accept.
//  ALU_ctrl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT, 0110 SRL,
//   0111 SRA, 1000 BGE, 1001 XOR, 1111 pass-op2. No other codes are emitted.
//  Decode (opcode[6:0], funct3, funct7[5]); op1=rs1_data in every case:
//   0110011 R: f3 000 ADD/SUB(f7[5]), 001 SLL, 010 SLT, 100 XOR, 101 SRL/SRA(f7[5]),
//    110 OR, 111 AND; op2=rs2_data; f3=011 (SLTU) -> illegal.
//   0010011 I: same f3 map, no SUB; SRAI when f7[5]=1; op2=imm; f3=011 -> illegal.
//   0000011 load, 0100011 store, 1100111 JALR: ADD, op2=imm.
//   1100011 branch: op2=rs2_data, is_branch=1; f3 000 SUB, 001 SUB+br_invert,
//    100 SLT, 101 BGE; other f3 -> illegal.
//   0110111 LUI: 1111, op2=imm. Any other opcode -> illegal, op1=op2=0, flags 0.
//  Shift amounts are passed unmasked; ALU uses full op2.
//  Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready.
//   Decoded entry lands in the output slot on the accept edge if the slot is empty or
//   being consumed; otherwise it lands in the skid slot. skid_valid=1 drops in_ready.
//   Consume with skid_valid=1: skid moves to output slot, skid_valid clears next edge.
//   Output fields are held stable while out_valid=1 and out_ready=0.
//  Ordering: strictly in order; no entry dropped or duplicated except by flush/reset.
//  Flush: synchronous; at the edge, out_valid=0 and skid_valid=0; any same-cycle accept
//   is discarded (flush beats accept and consume). in_ready=1 the cycle after.
//  Simultaneous accept+consume with skid empty: new entry replaces output, out_valid
//   stays 1 (back-to-back, 1 instr/cycle).
//  Reset mid-operation: all held entries lost immediately; no partial entry survives.
//  illegal entries still flow through the handshake like normal entries.
// TESTING
//  1 reset, in_valid=1 instr=0x40208033 (sub), rs1=7 rs2=3 -> next cycle out_valid=1,
//    alu_ctrl=0001, op1=7, op2=3, illegal=0.
//  2 addi x1,x0,-1 (0xFFF00093), imm=0xFFFFFFFF -> alu_ctrl=0000, op2=0xFFFFFFFF.
//  3 out_ready=0, push A then B -> out=A held, skid holds B, in_ready=0; out_ready=1
//    -> A consumed, B on output next cycle, in_ready=1.
//  4 bne (f3=001) -> alu_ctrl=0001, is_branch=1, br_invert=1; bge -> 1000, br_invert=0.
//  5 out/skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed-cycle instr never appears.
//  6 opcode 0x73 and sltu -> illegal=1, alu_ctrl=0000; rst_n low mid-stream -> all 0.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake bundle between regfile read, the ALU issue stage and the ALU.
// The master modport is the issue stage's view; slave is its environment.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] imm;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [3:0]            alu_ctrl;
  logic                  is_branch;
  logic                  br_invert;
  logic                  illegal;

  modport master (
    input  in_valid, instr, rs1_data, rs2_data, imm, flush, out_ready,
    output in_ready, out_valid, op1, op2, alu_ctrl, is_branch, br_invert, illegal
  );

  modport slave (
    output in_valid, instr, rs1_data, rs2_data, imm, flush, out_ready,
    input  in_ready, out_valid, op1, op2, alu_ctrl, is_branch, br_invert, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes to the 4-bit ALU control code, selects operands and
// presents them through a registered output slot backed by a one-entry skid buffer.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.master bus
);

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_AND  = 4'b0010;
  localparam logic [3:0] CTRL_OR   = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SLT  = 4'b0101;
  localparam logic [3:0] CTRL_SRL  = 4'b0110;
  localparam logic [3:0] CTRL_SRA  = 4'b0111;
  localparam logic [3:0] CTRL_BGE  = 4'b1000;
  localparam logic [3:0] CTRL_XOR  = 4'b1001;
  localparam logic [3:0] CTRL_PASS = 4'b1111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [3:0]            alu_ctrl;
    logic                  is_branch;
    logic                  br_invert;
    logic                  illegal;
  } entry_t;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       f7b5_s;
  entry_t     dec_s;
  entry_t     out_r, out_n;
  entry_t     skid_r, skid_n;
  logic       out_valid_r, out_valid_n;
  logic       skid_valid_r, skid_valid_n;
  logic       accept_s, consume_s;

  assign opcode_s  = bus.instr[6:0];
  assign funct3_s  = bus.instr[14:12];
  assign f7b5_s    = bus.instr[30];
  assign accept_s  = bus.in_valid & ~skid_valid_r;
  assign consume_s = out_valid_r & bus.out_ready;

  // Instruction decode; unsupported encodings leave alu_ctrl and branch flags at zero.
  always_comb begin
    dec_s     = '0;
    dec_s.op1 = bus.rs1_data;
    dec_s.op2 = bus.rs2_data;
    case (opcode_s)
      OPC_R, OPC_I: begin
        dec_s.op2 = (opcode_s == OPC_I) ? bus.imm : bus.rs2_data;
        case (funct3_s)
          3'b000:  dec_s.alu_ctrl = (opcode_s == OPC_R && f7b5_s) ? CTRL_SUB : CTRL_ADD;
          3'b001:  dec_s.alu_ctrl = CTRL_SLL;
          3'b010:  dec_s.alu_ctrl = CTRL_SLT;
          3'b100:  dec_s.alu_ctrl = CTRL_XOR;
          3'b101:  dec_s.alu_ctrl = f7b5_s ? CTRL_SRA : CTRL_SRL;
          3'b110:  dec_s.alu_ctrl = CTRL_OR;
          3'b111:  dec_s.alu_ctrl = CTRL_AND;
          default: dec_s.illegal  = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_s.alu_ctrl = CTRL_ADD;
        dec_s.op2      = bus.imm;
      end
      OPC_BRANCH: begin
        case (funct3_s)
          3'b000: begin
            dec_s.alu_ctrl  = CTRL_SUB;
            dec_s.is_branch = 1'b1;
          end
          3'b001: begin
            dec_s.alu_ctrl  = CTRL_SUB;
            dec_s.is_branch = 1'b1;
            dec_s.br_invert = 1'b1;
          end
          3'b100: begin
            dec_s.alu_ctrl  = CTRL_SLT;
            dec_s.is_branch = 1'b1;
          end
          3'b101: begin
            dec_s.alu_ctrl  = CTRL_BGE;
            dec_s.is_branch = 1'b1;
          end
          default: dec_s.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_s.alu_ctrl = CTRL_PASS;
        dec_s.op2      = bus.imm;
      end
      default: begin
        dec_s.illegal = 1'b1;
        dec_s.op1     = '0;
        dec_s.op2     = '0;
      end
    endcase
  end

  // Slot/skid next state; flush wins over any accept or consume in the same cycle.
  always_comb begin
    out_n        = out_r;
    skid_n       = skid_r;
    out_valid_n  = out_valid_r;
    skid_valid_n = skid_valid_r;
    if (bus.flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (skid_valid_r) begin
      if (consume_s) begin
        out_n        = skid_r;
        out_valid_n  = 1'b1;
        skid_valid_n = 1'b0;
      end else begin
        out_n = out_r;
      end
    end else if (accept_s) begin
      if (!out_valid_r || consume_s) begin
        out_n       = dec_s;
        out_valid_n = 1'b1;
      end else begin
        skid_n       = dec_s;
        skid_valid_n = 1'b1;
      end
    end else if (consume_s) begin
      out_valid_n = 1'b0;
    end else begin
      out_valid_n = out_valid_r;
    end
  end

  // State registers for the output slot and skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      out_r        <= out_n;
      skid_r       <= skid_n;
      out_valid_r  <= out_valid_n;
      skid_valid_r <= skid_valid_n;
    end
  end

  assign bus.in_ready  = ~skid_valid_r;
  assign bus.out_valid = out_valid_r;
  assign bus.op1       = out_r.op1;
  assign bus.op2       = out_r.op2;
  assign bus.alu_ctrl  = out_r.alu_ctrl;
  assign bus.is_branch = out_r.is_branch;
  assign bus.br_invert = out_r.br_invert;
  assign bus.illegal   = out_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder fills an expected queue on
// accept; entries are popped and compared on consume, occupancy predicts valid/ready.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  alu_issue_if #(.DATA_WIDTH(32)) bus ();

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic        br;
    logic        inv;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int NI = 24;
  logic [31:0] instr_tab [NI] = '{
    32'h00208033, 32'h40208033, 32'h00209033, 32'h0020A033, 32'h0020C033, 32'h0020D033,
    32'h4020D033, 32'h0020E033, 32'h0020F033, 32'h0020B033, 32'hFFF00093, 32'h4010D093,
    32'h0020C093, 32'h0000A083, 32'h0020A023, 32'h000080E7, 32'h00208063, 32'h00209063,
    32'h0020C063, 32'h0020D063, 32'h0020E063, 32'h123450B7, 32'h00000073, 32'h0000B093
  };

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] im);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[30];
    e  = '0;
    e.op1 = a;
    if (op == 7'h33 || op == 7'h13) begin
      e.op2 = (op == 7'h33) ? b : im;
      if (f3 == 3'd0)      e.ctrl = (op == 7'h33 && f7) ? 4'd1 : 4'd0;
      else if (f3 == 3'd1) e.ctrl = 4'd4;
      else if (f3 == 3'd2) e.ctrl = 4'd5;
      else if (f3 == 3'd4) e.ctrl = 4'd9;
      else if (f3 == 3'd5) e.ctrl = f7 ? 4'd7 : 4'd6;
      else if (f3 == 3'd6) e.ctrl = 4'd3;
      else if (f3 == 3'd7) e.ctrl = 4'd2;
      else                 e.ill  = 1'b1;
    end else if (op == 7'h03 || op == 7'h23 || op == 7'h67) begin
      e.op2 = im;
    end else if (op == 7'h63) begin
      e.op2 = b;
      if (f3 == 3'd0 || f3 == 3'd1) begin
        e.ctrl = 4'd1; e.br = 1'b1; e.inv = (f3 == 3'd1);
      end else if (f3 == 3'd4) begin
        e.ctrl = 4'd5; e.br = 1'b1;
      end else if (f3 == 3'd5) begin
        e.ctrl = 4'd8; e.br = 1'b1;
      end else begin
        e.ill = 1'b1;
      end
    end else if (op == 7'h37) begin
      e.ctrl = 4'hF;
      e.op2  = im;
    end else begin
      e.op1 = 32'd0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock of stimulus: drive, check against model occupancy, then update the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic rdy, input logic fl);
    exp_t e;
    int   occ;
    @(negedge clk);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.imm       = im;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    occ = sb_q.size();
    check_val("in_ready", 64'(bus.in_ready), 64'(occ < 2));
    check_val("out_valid", 64'(bus.out_valid), 64'(occ > 0));
    if (fl) begin
      sb_q.delete();
    end else begin
      if (rdy && occ > 0) begin
        e = sb_q.pop_front();
        check_val("alu_ctrl", 64'(bus.alu_ctrl), 64'(e.ctrl));
        check_val("op1", 64'(bus.op1), 64'(e.op1));
        check_val("op2", 64'(bus.op2), 64'(e.op2));
        check_val("flags", 64'({bus.is_branch, bus.br_invert, bus.illegal}),
                  64'({e.br, e.inv, e.ill}));
      end
      if (v && occ < 2) sb_q.push_back(ref_decode(ins, a, b, im));
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.rs1_data  = 32'd0;
    bus.rs2_data  = 32'd0;
    bus.imm       = 32'd0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val(tag, {bus.op1, bus.op2},
              64'd0);
    check_val(tag, 64'({bus.out_valid, bus.in_ready, bus.alu_ctrl,
                        bus.is_branch, bus.br_invert, bus.illegal}), 64'b01_0000_000);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero_outputs("reset");

    // sub then addi, consumed back to back
    cycle(1'b1, 32'h40208033, 32'd7, 32'd3, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFF00093, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // stall: A held, B in skid, then drain
    cycle(1'b1, 32'h00208033, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020F033, 32'd30, 32'd40, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020E033, 32'd50, 32'd60, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // bne and bge
    cycle(1'b1, 32'h00209063, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0020D063, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // flush with both slots full, then with one slot full and an accept pending
    cycle(1'b1, 32'h00208033, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208033, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208033, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00208033, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020C033, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0020A033, 32'd6, 32'd6, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // illegal: ecall and sltu
    cycle(1'b1, 32'h00000073, 32'd11, 32'd12, 32'd13, 1'b1, 1'b0);
    cycle(1'b1, 32'h0020B033, 32'd14, 32'd15, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), instr_tab[$urandom_range(0, NI - 1)],
            $urandom, $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end

    // reset in the middle of a stalled stream
    cycle(1'b1, 32'h00208033, 32'd21, 32'd22, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208033, 32'd23, 32'd24, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    sb_q.delete();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b1, 32'h123450B7, 32'd1, 32'd2, 32'h12345000, 1'b1, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++)
      cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_val("drain", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
